// File: rtl/mpu_prog_seq.sv
// Purpose: CSR-programmed sequencer that validates staged MPU region writes and issues one prog_en strobe.
// Latency: CMD write at edge N -> CHECK in cycle N+1 -> prog_en high in cycle N+2.
// Backpressure: none; staging/CMD writes while BUSY are dropped and flagged on csr_err.
// Option: define MPU_PROG_SHADOW_EN to keep a per-region shadow readable through BASE/LIMIT/ATTR.
module mpu_prog_seq #(
   parameter int NREG = 8,
   localparam int IDXW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            csr_we,
   input  logic            csr_re,
   input  logic [2:0]      csr_addr,
   input  logic [31:0]     csr_wdata,
   output logic [31:0]     csr_rdata,
   output logic            csr_err,
   output logic [31:0]     smpuctl_q,
   output logic            prog_en,
   output logic [IDXW-1:0] prog_idx,
   output logic [70:0]     prog_region
);

   // 70 significant bits; the top bit of prog_region is reserved and driven 0.
   typedef struct packed {
      logic        valid;
      logic [31:0] base;
      logic [31:0] limit;
      logic        r;
      logic        w;
      logic        x;
      logic        user_ok;
      logic        is_ispace;
   } region_t;

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] sel_q;
   logic [31:0]     base_q, limit_q;
   logic [4:0]      attr_q;
   logic            commit_q;
   logic            lock_q;
   logic [2:0]      stat_q;
   region_t         region_q, new_region;
   logic            busy, wr_ok, cmd_go, accept, rej_lock, rej_args;
   logic [2:0]      stat_clr;

   assign busy   = (state_q != S_IDLE);
   assign wr_ok  = csr_we && !busy;
   assign cmd_go = wr_ok && (csr_addr == 3'd4) && (csr_wdata[0] || csr_wdata[1]);

   assign smpuctl_q   = {30'b0, busy, lock_q};
   assign prog_region = {1'b0, region_q};

   // Region image presented at issue: staging for COMMIT, all-zero for INVAL.
   always_comb begin
      new_region = '0;
      if (commit_q) begin
         new_region.valid     = 1'b1;
         new_region.base      = base_q;
         new_region.limit     = limit_q;
         new_region.r         = attr_q[0];
         new_region.w         = attr_q[1];
         new_region.x         = attr_q[2];
         new_region.user_ok   = attr_q[3];
         new_region.is_ispace = attr_q[4];
      end
   end

   // FSM next state and CHECK verdict; lock outranks argument sanity, INVAL skips the range test.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      rej_lock = 1'b0;
      rej_args = 1'b0;
      case (state_q)
         S_IDLE:  if (cmd_go) state_d = S_CHECK;
         S_CHECK: begin
            if (lock_q)                            rej_lock = 1'b1;
            else if (commit_q && limit_q < base_q) rej_args = 1'b1;
            else                                   accept   = 1'b1;
            state_d = accept ? S_ISSUE : S_IDLE;
         end
         S_ISSUE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Staging registers and command type; only writable while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q    <= '0;
         base_q   <= '0;
         limit_q  <= '0;
         attr_q   <= '0;
         commit_q <= 1'b0;
      end else if (wr_ok) begin
         case (csr_addr)
            3'd0: sel_q   <= csr_wdata[IDXW-1:0];
            3'd1: base_q  <= csr_wdata;
            3'd2: limit_q <= csr_wdata;
            3'd3: attr_q  <= csr_wdata[4:0];
            3'd4: if (cmd_go) commit_q <= csr_wdata[0];
            default: ;
         endcase
      end
   end

   assign stat_clr = (csr_we && csr_addr == 3'd6) ? csr_wdata[2:0] : 3'b000;

   // Sticky lock, W1C status (hardware set beats clear), and error flag for dropped writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q  <= 1'b0;
         stat_q  <= '0;
         csr_err <= 1'b0;
      end else begin
         if (csr_we && csr_addr == 3'd5 && csr_wdata[0]) lock_q <= 1'b1;
         stat_q  <= (stat_q & ~stat_clr) | {accept, rej_args, rej_lock};
         csr_err <= csr_we && busy && (csr_addr < 3'd5);
      end
   end

   // Issue strobe and held region/index outputs, loaded as CHECK accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_en  <= 1'b0;
         prog_idx <= '0;
         region_q <= '0;
      end else begin
         prog_en <= accept;
         if (accept) begin
            prog_idx <= sel_q;
            region_q <= new_region;
         end
      end
   end

`ifdef MPU_PROG_SHADOW_EN
   region_t shadow_q [NREG];
   region_t rd_reg;

   // Shadow copy of every issued region, indexed by region number.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
      end else if (accept) begin
         shadow_q[sel_q] <= new_region;
      end
   end

   assign rd_reg = shadow_q[sel_q];
`endif

   // CSR read mux; a simultaneous write suppresses the read data.
   always_comb begin
      csr_rdata = '0;
      if (csr_re && !csr_we) begin
         case (csr_addr)
            3'd0: csr_rdata[IDXW-1:0] = sel_q;
`ifdef MPU_PROG_SHADOW_EN
            3'd1: csr_rdata = rd_reg.base;
            3'd2: csr_rdata = rd_reg.limit;
            3'd3: csr_rdata = {26'b0, rd_reg.valid, rd_reg.is_ispace, rd_reg.user_ok,
                               rd_reg.x, rd_reg.w, rd_reg.r};
`else
            3'd1: csr_rdata = base_q;
            3'd2: csr_rdata = limit_q;
            3'd3: csr_rdata = {27'b0, attr_q};
`endif
            3'd5: csr_rdata = {30'b0, busy, lock_q};
            3'd6: csr_rdata = {29'b0, stat_q};
            default: csr_rdata = '0;
         endcase
      end
   end

endmodule
